// File: rtl/uart_alu_interface_pkg.sv
// Opcode values and helpers shared by the UART/ALU glue logic and the ALU.
// Opcodes are defined once here so both blocks agree on the encoding.
package uart_alu_interface_pkg;
    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;

    function automatic logic is_legal_op(input logic [NB_OP_DEF-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/uart_alu_interface_frame_timer.sv
// Inter-byte idle counter with synchronous clear, count enable and terminal-count flag.
module frame_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   cnt <= '0;
        else if (i_clr) cnt <= '0;
        else if (i_en)  cnt <= cnt + W'(1);
    end

    // Fires in the cycle whose edge brings the count to TIMEOUT_CYC-1, so the
    // registered error lands exactly TIMEOUT_CYC cycles after the accepted byte.
    assign o_tc = i_en && !i_clr && (cnt == LAST);
endmodule

// File: rtl/uart_alu_interface.sv
// Assembles A/B/opcode frames from the UART receiver, strobes the ALU, and
// returns the one-byte result to the UART transmitter.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_OP       = NB_OP_DEF,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_alu_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_err_op,
    output logic               o_err_timeout
);
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
    } state_t;

    state_t           state;
    logic             in_frame;
    logic             tmr_clr;
    logic             tmr_tc;
    logic [NB_OP-1:0] op_byte;
    logic             op_ok;

    assign in_frame = (state == WAIT_B) || (state == WAIT_OP);
    assign tmr_clr  = (state == WAIT_A) || (in_frame && i_rx_done);
    assign op_byte  = i_rx_data[NB_OP-1:0];
    assign op_ok    = is_legal_op(NB_OP_DEF'(op_byte));

    frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (tmr_clr),
        .i_en    (in_frame),
        .o_tc    (tmr_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= WAIT_A;
            o_datoA       <= '0;
            o_datoB       <= '0;
            o_operation   <= '0;
            o_alu_valid   <= 1'b0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_err_op      <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            o_alu_valid   <= 1'b0;
            o_tx_start    <= 1'b0;
            o_err_op      <= 1'b0;
            o_err_timeout <= 1'b0;
            case (state)
                WAIT_A: if (i_rx_done) begin
                    o_datoA <= i_rx_data;
                    state   <= WAIT_B;
                end
                WAIT_B: if (i_rx_done) begin
                    o_datoB <= i_rx_data;
                    state   <= WAIT_OP;
                end else if (tmr_tc) begin
                    o_err_timeout <= 1'b1;
                    state         <= WAIT_A;
                end
                WAIT_OP: if (i_rx_done) begin
                    if (op_ok) begin
                        o_operation <= op_byte;
                        o_alu_valid <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        o_err_op <= 1'b1;
                        state    <= WAIT_A;
                    end
                end else if (tmr_tc) begin
                    o_err_timeout <= 1'b1;
                    state         <= WAIT_A;
                end
                // Operands are stable during EXEC, so the ALU output is valid here.
                EXEC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end
                SEND:    state <= WAIT_TX;
                WAIT_TX: if (i_tx_done) state <= WAIT_A;
                default: state <= WAIT_A;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a behavioural ALU in the loop.
module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done, tx_done;
    logic [7:0] alu_res;
    logic [7:0] dato_a, dato_b, tx_data;
    logic [5:0] operation;
    logic       alu_valid, tx_start, err_op, err_to;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_start = 0, n_err_op = 0, n_err_to = 0;

    always #5 clk = ~clk;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(100)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .i_tx_done     (tx_done),
        .i_alu_result  (alu_res),
        .o_datoA       (dato_a),
        .o_datoB       (dato_b),
        .o_operation   (operation),
        .o_alu_valid   (alu_valid),
        .o_tx_data     (tx_data),
        .o_tx_start    (tx_start),
        .o_err_op      (err_op),
        .o_err_timeout (err_to)
    );

    always_comb begin
        alu_res = 8'h00;
        case (operation)
            OP_ADD: alu_res = dato_a + dato_b;
            OP_SUB: alu_res = dato_a - dato_b;
            OP_AND: alu_res = dato_a & dato_b;
            OP_OR:  alu_res = dato_a | dato_b;
            OP_XOR: alu_res = dato_a ^ dato_b;
            OP_SRA: alu_res = $unsigned($signed(dato_a) >>> dato_b);
            OP_SRL: alu_res = dato_a >> dato_b;
            OP_NOR: alu_res = ~(dato_a | dato_b);
            default: alu_res = 8'h00;
        endcase
    end

    // Strobe counters sample the value held during the cycle that just ended.
    always @(posedge clk) begin
        if (alu_valid) n_valid  <= n_valid + 1;
        if (tx_start)  n_start  <= n_start + 1;
        if (err_op)    n_err_op <= n_err_op + 1;
        if (err_to)    n_err_to <= n_err_to + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_done_pulse();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] op, input logic [7:0] exp);
        send_byte(op);
        chk({tag, ".valid"}, alu_valid, 1);
        chk({tag, ".a"}, dato_a, a);
        chk({tag, ".b"}, dato_b, b);
        chk({tag, ".op"}, operation, op[5:0]);
        chk({tag, ".start_early"}, tx_start, 0);
        @(negedge clk);
        chk({tag, ".start"}, tx_start, 1);
        chk({tag, ".valid_off"}, alu_valid, 0);
        chk({tag, ".tx_data"}, tx_data, exp);
        @(negedge clk);
        chk({tag, ".start_off"}, tx_start, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp);
        send_byte(a);
        idle(10);
        send_byte(b);
        idle(10);
        finish_frame(tag, a, b, op, exp);
    endtask

    initial begin
        int v0, s0, e0, t0;
        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
        idle(3);
        chk("rst.a", dato_a, 0);
        chk("rst.b", dato_b, 0);
        chk("rst.op", operation, 0);
        chk("rst.valid", alu_valid, 0);
        chk("rst.tx_data", tx_data, 0);
        chk("rst.start", tx_start, 0);
        chk("rst.err", {err_op, err_to}, 0);
        rst_n = 1'b1;
        idle(2);

        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        idle(3);
        tx_done_pulse();

        run_frame("sra", 8'hF0, 8'h02, 8'h03, 8'hFC);
        tx_done_pulse();
        run_frame("nor", 8'h0F, 8'h0F, 8'h27, 8'hF0);
        tx_done_pulse();

        v0 = n_valid; s0 = n_start; e0 = n_err_op;
        send_byte(8'h01); idle(4);
        send_byte(8'h02); idle(4);
        send_byte(8'h3F);
        chk("ill.err_op", err_op, 1);
        chk("ill.valid", alu_valid, 0);
        chk("ill.op_held", operation, 6'h27);
        @(negedge clk);
        chk("ill.err_op_off", err_op, 0);
        idle(5);
        chk("ill.n_err_op", n_err_op - e0, 1);
        chk("ill.n_valid", n_valid - v0, 0);
        chk("ill.n_start", n_start - s0, 0);
        run_frame("ill_next", 8'h01, 8'h02, 8'h20, 8'h03);
        tx_done_pulse();

        // Timeout: A byte accepted in cycle N, pulse expected in cycle N+100.
        t0 = n_err_to;
        send_byte(8'h11);
        idle(98);
        chk("to.before", err_to, 0);
        @(negedge clk);
        chk("to.pulse", err_to, 1);
        @(negedge clk);
        chk("to.pulse_off", err_to, 0);
        chk("to.n_err_to", n_err_to - t0, 1);
        run_frame("to_next", 8'h04, 8'h04, 8'h22, 8'h00);
        tx_done_pulse();

        // B byte lands in the expiry cycle (N+99) and must win.
        t0 = n_err_to;
        send_byte(8'h09);
        idle(98);
        send_byte(8'h01);
        idle(5);
        chk("coin.no_err", n_err_to - t0, 0);
        finish_frame("coin", 8'h09, 8'h01, 8'h20, 8'h0A);
        tx_done_pulse();

        run_frame("wtx", 8'h07, 8'h01, 8'h22, 8'h06);
        v0 = n_valid;
        send_byte(8'h55);
        idle(2);
        chk("wtx.a", dato_a, 8'h07);
        chk("wtx.tx_data", tx_data, 8'h06);
        chk("wtx.n_valid", n_valid - v0, 0);
        tx_done_pulse();
        run_frame("wtx_next", 8'h02, 8'h03, 8'h24, 8'h02);
        tx_done_pulse();

        // No timeout while idle in WAIT_A; stray tx_done is harmless.
        t0 = n_err_to;
        idle(150);
        tx_done_pulse();
        chk("idle.no_err", n_err_to - t0, 0);

        send_byte(8'h77);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("mrst.a", dato_a, 0);
        chk("mrst.b", dato_b, 0);
        chk("mrst.op", operation, 0);
        chk("mrst.tx_data", tx_data, 0);
        chk("mrst.strobes", {alu_valid, tx_start, err_op, err_to}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("mrst_next", 8'h06, 8'h03, 8'h26, 8'h05);
        tx_done_pulse();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
